jtbubl_gfx_romslot: RTL and testbench

SDRAM-side responder for the video graphics ROM fetch port. It accepts the 18-bit, 32-bit-wide requests the tile/sprite engine issues on `gfx_addr`/`gfx_cs` and turns them into two-beat 16-bit SDRAM reads. It returns assembled data on `gfx_data` with a `gfx_ok` qualifier. It sits between the video block and the SDRAM controller and keeps a one-entry cache of the last fetched word.

---
 rtl/jtbubl_gfx_romslot.sv | 107 ++++++++++
 tb/tb_jtbubl_gfx_romslot.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtbubl_gfx_romslot.sv
// Graphics ROM slot: turns 32-bit gfx fetches into two-beat 16-bit SDRAM reads
// and keeps the last fetched word in a one-entry cache.
module jtbubl_gfx_romslot #(
   parameter logic [21:0] OFFSET = 22'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] gfx_addr,
   input  logic        gfx_cs,
   output logic [31:0] gfx_data,
   output logic        gfx_ok,
   output logic [21:0] sdram_addr,
   output logic        sdram_req,
   input  logic        sdram_ack,
   input  logic        sdram_dst,
   input  logic [15:0] sdram_din,
   output logic [1:0]  dbg_state_o
);

   // Handshake: sdram_req stays high from entry to REQ until sdram_ack is
   // sampled; each sdram_dst pulse in BEAT0/BEAT1 carries one 16-bit beat.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_BEAT0 = 2'd2,
      S_BEAT1 = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [17:0] req_addr_q, req_addr_d;
   logic [17:0] cached_addr_q, cached_addr_d;
   logic [31:0] cached_data_q, cached_data_d;
   logic        valid_q, valid_d;
   logic [15:0] low_q, low_d;
   logic [21:0] sdram_addr_q, sdram_addr_d;

   assign gfx_ok      = gfx_cs & valid_q & (gfx_addr == cached_addr_q);
   assign gfx_data    = cached_data_q;
   assign sdram_addr  = sdram_addr_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d       = state_q;
      req_addr_d    = req_addr_q;
      cached_addr_d = cached_addr_q;
      cached_data_d = cached_data_q;
      valid_d       = valid_q;
      low_d         = low_q;
      sdram_addr_d  = sdram_addr_q;
      sdram_req     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (gfx_cs && !gfx_ok) begin
               req_addr_d   = gfx_addr;
               // Address computed here so it is stable for the whole REQ phase
               sdram_addr_d = OFFSET + {3'b000, gfx_addr, 1'b0};
               valid_d      = 1'b0;
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            sdram_req = 1'b1;
            if (sdram_ack) begin
               state_d = S_BEAT0;
            end
         end
         S_BEAT0: begin
            if (sdram_dst) begin
               low_d   = sdram_din;
               state_d = S_BEAT1;
            end
         end
         S_BEAT1: begin
            if (sdram_dst) begin
               cached_data_d = {sdram_din, low_q};
               cached_addr_d = req_addr_q;
               valid_d       = 1'b1;
               state_d       = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         req_addr_q    <= '0;
         cached_addr_q <= '0;
         cached_data_q <= '0;
         valid_q       <= 1'b0;
         low_q         <= '0;
         sdram_addr_q  <= '0;
      end else begin
         state_q       <= state_d;
         req_addr_q    <= req_addr_d;
         cached_addr_q <= cached_addr_d;
         cached_data_q <= cached_data_d;
         valid_q       <= valid_d;
         low_q         <= low_d;
         sdram_addr_q  <= sdram_addr_d;
      end
   end

endmodule

// File: tb/tb_jtbubl_gfx_romslot.sv
// Bench for jtbubl_gfx_romslot: acts as the SDRAM controller and checks the
// gfx side against a cache/memory model of the fetch port.
module tb_jtbubl_gfx_romslot;

   localparam logic [21:0] OFF0 = 22'h100000;
   localparam logic [21:0] OFF1 = 22'h3FFFFE;

   // clock / reset
   logic clk;
   logic rst;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [17:0] gfx_addr;
   logic        gfx_cs;
   logic [31:0] gfx_data;
   logic        gfx_ok;
   logic [21:0] sdram_addr;
   logic        sdram_req;
   logic        sdram_ack;
   logic        sdram_dst;
   logic [15:0] sdram_din;
   logic [1:0]  dbg0;

   logic [17:0] gfx_addr1;
   logic        gfx_cs1;
   logic [31:0] gfx_data1;
   logic        gfx_ok1;
   logic [21:0] sdram_addr1;
   logic        sdram_req1;
   logic        sdram_ack1;
   logic        sdram_dst1;
   logic [15:0] sdram_din1;
   logic [1:0]  dbg1;

   jtbubl_gfx_romslot #(.OFFSET(OFF0)) u_dut0 (
      .clk(clk), .rst(rst),
      .gfx_addr(gfx_addr), .gfx_cs(gfx_cs),
      .gfx_data(gfx_data), .gfx_ok(gfx_ok),
      .sdram_addr(sdram_addr), .sdram_req(sdram_req),
      .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_din(sdram_din),
      .dbg_state_o(dbg0)
   );

   jtbubl_gfx_romslot #(.OFFSET(OFF1)) u_dut1 (
      .clk(clk), .rst(rst),
      .gfx_addr(gfx_addr1), .gfx_cs(gfx_cs1),
      .gfx_data(gfx_data1), .gfx_ok(gfx_ok1),
      .sdram_addr(sdram_addr1), .sdram_req(sdram_req1),
      .sdram_ack(sdram_ack1), .sdram_dst(sdram_dst1), .sdram_din(sdram_din1),
      .dbg_state_o(dbg1)
   );

   int vectors    = 0;
   int miscompares = 0;

   // reference model: cache contents plus queue of words handed out by "SDRAM"
   bit          m_valid;
   logic [17:0] m_addr;
   logic [31:0] m_data;
   logic [31:0] exp_q[$];

   function automatic logic [15:0] mem(input logic [21:0] a);
      return a[15:0] ^ {a[21:16], 10'h2A5} ^ 16'hC3A1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag);
      logic exp_ok;
      exp_ok = gfx_cs && m_valid && (gfx_addr == m_addr);
      chk({tag, ":ok"}, {31'd0, gfx_ok}, {31'd0, exp_ok});
      chk({tag, ":data"}, gfx_data, m_data);
   endtask

   // Caller has gfx_cs/gfx_addr presenting a miss on address a in an IDLE cycle.
   task automatic fetch(input logic [17:0] a, input int ack_dly, input bit dst_ack,
                        input int g0, input int g1, input bit req_cs,
                        input bit mid_cs, input logic [17:0] mid_addr,
                        input logic [15:0] lo, input logic [15:0] hi);
      logic [21:0] exp_addr;
      exp_addr = OFF0 + 22'(a) * 22'd2;
      #1;
      check_out("miss");
      chk("miss:req", {31'd0, sdram_req}, 32'd0);
      exp_q.push_back({hi, lo});
      tick();
      m_valid = 1'b0;
      gfx_cs  = req_cs;
      for (int i = 0; i < ack_dly; i++) begin
         sdram_dst = ($urandom_range(0, 1) == 1);
         sdram_din = 16'($urandom);
         #1;
         chk("req:hold", {31'd0, sdram_req}, 32'd1);
         chk("req:addr", {10'd0, sdram_addr}, {10'd0, exp_addr});
         tick();
         sdram_dst = 1'b0;
      end
      sdram_ack = 1'b1;
      sdram_dst = dst_ack;
      sdram_din = ~lo;
      #1;
      chk("ack:req", {31'd0, sdram_req}, 32'd1);
      chk("ack:addr", {10'd0, sdram_addr}, {10'd0, exp_addr});
      tick();
      sdram_ack = 1'b0;
      sdram_dst = 1'b0;
      gfx_cs    = mid_cs;
      gfx_addr  = mid_addr;
      #1;
      chk("beat0:req", {31'd0, sdram_req}, 32'd0);
      check_out("beat0");
      for (int i = 0; i < g0; i++) tick();
      sdram_dst = 1'b1;
      sdram_din = lo;
      tick();
      sdram_dst = 1'b0;
      for (int i = 0; i < g1; i++) begin
         check_out("beat1_wait");
         tick();
      end
      sdram_dst = 1'b1;
      sdram_din = hi;
      check_out("beat1");
      tick();
      sdram_dst = 1'b0;
      sdram_din = 16'($urandom);
      m_valid = 1'b1;
      m_addr  = a;
      m_data  = exp_q.pop_front();
      #1;
      check_out("done");
      chk("done:req", {31'd0, sdram_req}, 32'd0);
   endtask

   task automatic fetch_rand(input logic [17:0] a, input bit mid_cs, input logic [17:0] mid_addr);
      logic [21:0] sa;
      sa = OFF0 + 22'(a) * 22'd2;
      fetch(a, $urandom_range(0, 3), ($urandom_range(0, 1) == 1),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
            mid_cs, mid_addr, mem(sa), mem(sa + 22'd1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [17:0] pool [4];
      logic [17:0] a;
      bit          cs;
      pool[0] = 18'h00010;
      pool[1] = 18'h00011;
      pool[2] = 18'h3FFFF;
      pool[3] = 18'h00123;

      rst = 1'b1;
      gfx_cs = 1'b1; gfx_addr = 18'h00010;
      sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_din = 16'h0;
      gfx_cs1 = 1'b0; gfx_addr1 = 18'h0;
      sdram_ack1 = 1'b0; sdram_dst1 = 1'b0; sdram_din1 = 16'h0;
      m_valid = 1'b0; m_addr = '0; m_data = '0;
      repeat (3) tick();

      // reset state
      chk("rst:ok", {31'd0, gfx_ok}, 32'd0);
      chk("rst:data", gfx_data, 32'd0);
      chk("rst:req", {31'd0, sdram_req}, 32'd0);
      chk("rst:addr", {10'd0, sdram_addr}, 32'd0);
      chk("rst:req1", {31'd0, sdram_req1}, 32'd0);

      // first miss, exact timing: ack in cycle 1, beats in cycles 4 and 5
      rst = 1'b0;
      fetch(18'h00010, 0, 1'b0, 2, 0, 1'b1, 1'b1, 18'h00010, 16'hBEEF, 16'hDEAD);
      chk("first:data", gfx_data, 32'hDEADBEEF);
      chk("first:ok", {31'd0, gfx_ok}, 32'd1);

      // hold the same address: pure hits, no traffic
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold:req", {31'd0, sdram_req}, 32'd0);
         check_out("hold");
      end

      // address moves to 0x11 during BEAT0; that word is re-fetched right after
      gfx_addr = 18'h00030;
      fetch_rand(18'h00030, 1'b1, 18'h00011);
      fetch(18'h00011, 1, 1'b1, 1, 2, 1'b1, 1'b1, 18'h00011, 16'h1357, 16'h2468);
      chk("refetch:data", gfx_data, 32'h24681357);

      // gfx_cs dropped during REQ: transfer still completes and is cached
      gfx_addr = 18'h00040;
      fetch(18'h00040, 3, 1'b0, 0, 1, 1'b0, 1'b0, 18'h00040, 16'h0F0F, 16'hF0F0);
      gfx_cs = 1'b1;
      #1;
      chk("recs:ok", {31'd0, gfx_ok}, 32'd1);
      check_out("recs");
      tick();
      chk("recs:req", {31'd0, sdram_req}, 32'd0);

      // reset during BEAT1, then a stray beat
      gfx_addr = 18'h00020;
      #1;
      tick();
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      sdram_dst = 1'b1; sdram_din = 16'h1234;
      tick();
      sdram_dst = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      gfx_cs = 1'b0;
      m_valid = 1'b0; m_addr = '0; m_data = '0;
      #1;
      chk("mrst:data", gfx_data, 32'd0);
      chk("mrst:req", {31'd0, sdram_req}, 32'd0);
      chk("mrst:addr", {10'd0, sdram_addr}, 32'd0);
      sdram_dst = 1'b1; sdram_din = 16'h5678;
      tick();
      sdram_dst = 1'b0;
      tick();
      chk("stray:data", gfx_data, 32'd0);
      chk("stray:req", {31'd0, sdram_req}, 32'd0);
      gfx_cs = 1'b1; gfx_addr = 18'h00000;
      #1;
      chk("stray:ok0", {31'd0, gfx_ok}, 32'd0);
      gfx_addr = 18'h00020;
      fetch_rand(18'h00020, 1'b1, 18'h00020);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         a  = ($urandom_range(0, 4) == 0) ? 18'($urandom) : pool[$urandom_range(0, 3)];
         cs = ($urandom_range(0, 3) != 0);
         gfx_cs = cs; gfx_addr = a;
         #1;
         if (cs && !(m_valid && a == m_addr)) begin
            fetch_rand(a, ($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)]);
         end else begin
            check_out("idle");
            tick();
            chk("idle:req", {31'd0, sdram_req}, 32'd0);
         end
      end

      // address wrap on the second instance
      gfx_cs = 1'b0;
      gfx_cs1 = 1'b1; gfx_addr1 = 18'h00002;
      #1;
      chk("wrap:ok0", {31'd0, gfx_ok1}, 32'd0);
      tick();
      chk("wrap:req", {31'd0, sdram_req1}, 32'd1);
      chk("wrap:addr", {10'd0, sdram_addr1}, 32'h000002);
      sdram_ack1 = 1'b1;
      tick();
      sdram_ack1 = 1'b0;
      sdram_dst1 = 1'b1; sdram_din1 = 16'hAAAA;
      tick();
      sdram_din1 = 16'h5555;
      tick();
      sdram_dst1 = 1'b0;
      chk("wrap:ok", {31'd0, gfx_ok1}, 32'd1);
      chk("wrap:data", gfx_data1, 32'h5555AAAA);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
